// File: rtl/led_sched_pkg.sv
// led_sched_pkg: shared FSM state type and default timing constants for the LED scheduler
package led_sched_pkg;
    typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;
    localparam int DEF_PAT_W           = 8;
    localparam int DEF_TICK_DIV        = 1_000_000;
    localparam int DEF_DEBOUNCE_CYCLES = 100_000;
endpackage

// File: rtl/input_debouncer.sv
// input_debouncer: 2-flop synchroniser plus change-acceptance debounce for one switch input
module input_debouncer
    import led_sched_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk_10mhz,
    input  logic rst,
    input  logic raw,
    output logic db
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic          sync1_q, sync2_q, db_q, db_d, hit;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    always_comb begin
        cnt_inc = cnt_q + CW'(1);
        hit     = (sync2_q != db_q) && (cnt_inc == CW'(DEBOUNCE_CYCLES));
        db_d    = hit ? sync2_q : db_q;
        cnt_d   = (sync2_q == db_q || hit) ? '0 : cnt_inc;
    end
    always_ff @(posedge clk_10mhz or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end
    assign db = db_q;
endmodule

// File: rtl/led_blink_scheduler.sv
// led_blink_scheduler: round-robin time-sharing of one status LED between pattern-owning requesters
module led_blink_scheduler
    import led_sched_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int PAT_W           = DEF_PAT_W,
    parameter int TICK_DIV        = DEF_TICK_DIV,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic                            clk_10mhz,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_raw,
    input  logic [NUM_REQ-1:0][PAT_W-1:0]   pattern,
    output logic                            led,
    output logic [NUM_REQ-1:0]              grant,
    output logic                            busy,
    output logic                            tick
);
    localparam int PS_W = $clog2(TICK_DIV);
    localparam int BW   = $clog2(PAT_W);
    localparam int IW   = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] req_db;
    logic [PS_W-1:0]    pre_q, pre_d;
    state_t             state_q, state_d;
    logic [BW-1:0]      bit_q, bit_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [IW-1:0]      last_q, last_d, win, idx;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               led_q, led_d, pick, found;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_db
        input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk_10mhz (clk_10mhz),
            .rst       (rst),
            .raw       (req_raw[i]),
            .db        (req_db[i])
        );
    end

    assign tick  = pre_q == PS_W'(TICK_DIV - 1);
    assign pre_d = tick ? '0 : pre_q + PS_W'(1);

    // First requester strictly after the previous owner, wrapping around
    always_comb begin
        win   = last_q;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IW'((int'(last_q) + k) % NUM_REQ);
            if (!found && req_db[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        pat_d   = pat_q;
        last_d  = last_q;
        pick    = 1'b0;
        if (tick) begin
            case (state_q)
                IDLE: pick = |req_db;
                RUN: begin
                    bit_d   = bit_q + BW'(1);
                    state_d = (bit_q == BW'(PAT_W - 1)) ? GAP : RUN;
                end
                GAP: begin
                    pick    = |req_db;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        if (pick) begin
            state_d = RUN;
            pat_d   = pattern[win];
            bit_d   = '0;
            last_d  = win;
        end
        grant_d = (state_d == IDLE) ? '0 : pick ? NUM_REQ'(1) << win : grant_q;
        led_d   = (state_d == RUN) ? pat_d[bit_d] : 1'b0;
    end

    always_ff @(posedge clk_10mhz or posedge rst) begin
        if (rst) begin
            pre_q   <= '0;
            state_q <= IDLE;
            bit_q   <= '0;
            pat_q   <= '0;
            last_q  <= IW'(NUM_REQ - 1);
            grant_q <= '0;
            led_q   <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            state_q <= state_d;
            bit_q   <= bit_d;
            pat_q   <= pat_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            led_q   <= led_d;
        end
    end

    assign led   = led_q;
    assign grant = grant_q;
    assign busy  = state_q != IDLE;
endmodule

// File: tb/tb_led_blink_scheduler.sv
// tb_led_blink_scheduler: scoreboard bench against a slot-level reference model of the LED scheduler
module tb_led_blink_scheduler;
    localparam int N = 4, PW = 8, TD = 4, DEB = 3;

    logic                   clk_10mhz = 1'b0;
    logic                   rst = 1'b1;
    logic [N-1:0]           req_raw = '0;
    logic [N-1:0][PW-1:0]   pattern = '0;
    logic                   led, busy, tick;
    logic [N-1:0]           grant;

    always #5 clk_10mhz = ~clk_10mhz;

    led_blink_scheduler #(.NUM_REQ(N), .PAT_W(PW), .TICK_DIV(TD), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk_10mhz (clk_10mhz),
        .rst       (rst),
        .req_raw   (req_raw),
        .pattern   (pattern),
        .led       (led),
        .grant     (grant),
        .busy      (busy),
        .tick      (tick)
    );

    typedef struct packed {
        logic         led;
        logic [N-1:0] grant;
        logic         busy;
        logic         tick;
    } exp_t;

    exp_t          sb[$];
    int            compared = 0, mismatched = 0;
    int            obs[$];
    logic [N-1:0]  hist[$];
    logic [N-1:0]  m_db;
    logic [PW-1:0] m_pat;
    int            m_owner, m_pos, m_last, m_cyc;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        hist.delete();
        for (int k = 0; k < DEB + 2; k++) hist.push_back('0);
        m_owner = -1;
        m_pos   = 0;
        m_last  = N - 1;
        m_cyc   = 0;
        m_db    = '0;
        m_pat   = '0;
    endtask

    // An accepted level is one the synchronised input has held, against the current level, for DEB cycles
    task automatic model_step();
        logic [N-1:0] nxt_db;
        bit           t_now, all_diff;
        exp_t         e;
        t_now  = (m_cyc % TD) == TD - 1;
        nxt_db = m_db;
        hist.push_back(req_raw);
        if (hist.size() > DEB + 4) void'(hist.pop_front());
        for (int i = 0; i < N; i++) begin
            all_diff = 1'b1;
            for (int k = 2; k <= DEB + 1; k++)
                if (hist[hist.size() - 1 - k][i] == m_db[i]) all_diff = 1'b0;
            if (all_diff) nxt_db[i] = ~m_db[i];
        end
        if (t_now) begin
            if (m_owner < 0 || m_pos == PW) begin
                m_owner = -1;
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (m_last + k) % N;
                    if (m_owner < 0 && m_db[c]) m_owner = c;
                end
                if (m_owner >= 0) begin
                    m_last = m_owner;
                    m_pat  = pattern[m_owner];
                    m_pos  = 0;
                end
            end else begin
                m_pos++;
            end
        end
        m_db    = nxt_db;
        m_cyc++;
        e.led   = (m_owner >= 0 && m_pos < PW) ? m_pat[m_pos] : 1'b0;
        e.grant = (m_owner >= 0) ? N'(1) << m_owner : '0;
        e.busy  = m_owner >= 0;
        e.tick  = (m_cyc % TD) == TD - 1;
        sb.push_back(e);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk_10mhz or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    initial begin
        exp_t         e, got;
        logic [N-1:0] prev_g;
        prev_g = '0;
        forever begin
            @(negedge clk_10mhz);
            got = '{led: led, grant: grant, busy: busy, tick: tick};
            if (rst) begin
                chk("reset_outputs", 32'(got), 32'(0));
            end else if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("led_grant_busy_tick", 32'(got), 32'(e));
            end
            if (grant != prev_g && grant != '0) obs.push_back($clog2(grant));
            prev_g = grant;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_10mhz);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
    endtask

    task automatic wait_grant(input logic [N-1:0] m, input int budget);
        int k;
        k = 0;
        while (grant !== m && k < budget) begin
            cyc(1);
            k++;
        end
        chk("wait_grant", 32'(grant), 32'(m));
    endtask

    task automatic wait_ticks(input int n);
        int seen, k;
        seen = 0;
        k    = 0;
        while (seen < n && k < 100) begin
            cyc(1);
            k++;
            if (tick) seen++;
        end
        chk("wait_ticks", 32'(seen), 32'(n));
    endtask

    initial begin
        int exp_ord[4];
        exp_ord = '{0, 1, 3, 0};
        cyc(4);
        rst = 1'b0;
        cyc(20);
        chk("idle_after_reset", 32'({led, grant, busy}), 32'(0));

        for (int k = 0; k < 10; k++) begin
            req_raw[1] = ~req_raw[1];
            cyc(2);
        end
        chk("bounce_no_grant", 32'(grant), 32'(0));
        pattern[1] = 8'hA5;
        req_raw[1] = 1'b1;
        wait_grant(4'b0010, 40);
        cyc(40);
        req_raw = '0;
        cyc(60);

        rst = 1'b1;
        req_raw = 4'b1011;
        for (int i = 0; i < N; i++) pattern[i] = PW'($urandom);
        cyc(3);
        obs.delete();
        rst = 1'b0;
        cyc(170);
        for (int k = 0; k < 4; k++)
            chk("grant_order", 32'(obs.size() > k ? obs[k] : -1), 32'(exp_ord[k]));
        req_raw = '0;
        cyc(60);

        do_reset();
        pattern[2] = PW'($urandom);
        pattern[3] = PW'($urandom);
        req_raw = 4'b1100;
        wait_grant(4'b0100, 60);
        cyc(10);
        req_raw[2] = 1'b0;
        pattern[2] = ~pattern[2];
        wait_grant(4'b1000, 80);
        req_raw = '0;
        cyc(60);

        do_reset();
        pattern[0] = 8'hFF;
        req_raw = 4'b1011;
        wait_grant(4'b0001, 60);
        wait_ticks(3);
        chk("pre_reset_led", 32'(led), 32'(1));
        rst = 1'b1;
        #1;
        chk("async_led", 32'(led), 32'(0));
        chk("async_grant", 32'(grant), 32'(0));
        chk("async_busy", 32'(busy), 32'(0));
        cyc(2);
        rst = 1'b0;
        wait_grant(4'b0001, 60);
        req_raw = '0;
        cyc(60);

        do_reset();
        pattern[2] = PW'($urandom);
        req_raw = 4'b0100;
        wait_grant(4'b0100, 60);
        cyc(3 * (PW + 1) * TD - 10);
        chk("sole_grant_held", 32'(grant), 32'(4'b0100));
        req_raw = '0;
        cyc(80);
        chk("sole_end_busy", 32'(busy), 32'(0));
        chk("sole_end_grant", 32'(grant), 32'(0));

        do_reset();
        repeat (60) begin
            req_raw = N'($urandom);
            for (int i = 0; i < N; i++) pattern[i] = PW'($urandom);
            cyc($urandom_range(1, 15));
        end
        req_raw = '0;
        cyc(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
